// File: rtl/rv_ctrl_pkg.sv
// Shared opcode, funct and ALUop encodings plus the packed ALU control bundle
// used by the RV32I decode stage.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
    localparam logic [2:0] F3_W    = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // R-type and I-type use independent ALUop tables.
    localparam logic [3:0] ALU_R_ADD = 4'b0000;
    localparam logic [3:0] ALU_R_SUB = 4'b0001;
    localparam logic [3:0] ALU_R_XOR = 4'b0010;
    localparam logic [3:0] ALU_R_OR  = 4'b0011;
    localparam logic [3:0] ALU_R_AND = 4'b0100;
    localparam logic [3:0] ALU_R_SLL = 4'b0101;
    localparam logic [3:0] ALU_R_SRL = 4'b0110;
    localparam logic [3:0] ALU_R_SRA = 4'b0111;

    localparam logic [3:0] ALU_I_ADDI = 4'b0000;
    localparam logic [3:0] ALU_I_XORI = 4'b0001;
    localparam logic [3:0] ALU_I_ORI  = 4'b0010;
    localparam logic [3:0] ALU_I_ANDI = 4'b0011;
    localparam logic [3:0] ALU_I_SLLI = 4'b0100;
    localparam logic [3:0] ALU_I_SRAI = 4'b0101;
    localparam logic [3:0] ALU_I_SRLI = 4'b0110;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_SHAMT,
        IMM_S,
        IMM_B
    } imm_fmt_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       sftmd;
        logic       branch;
        logic       n_branch;
        logic       branch_lt;
        logic       branch_ge;
        logic       branch_ltu;
        logic       branch_geu;
    } alu_ctrl_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: selects and sign-extends the immediate field of an
// RV32I instruction according to the format chosen by the decoder.
import rv_ctrl_pkg::*;

module rv_imm_gen (
    input  imm_fmt_t    fmt,
    input  logic [31:0] instr,
    output logic [31:0] imm32
);

    // rs1/funct3/opcode never contribute to an immediate
    logic [14:0] unused_bits;
    assign unused_bits = {instr[19:12], instr[6:0]};

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:     imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_SHAMT: imm32 = {27'b0, instr[24:20]};
            IMM_S:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:     imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            default:   imm32 = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I decode stage: turns an instruction word into the ALU control
// bundle and immediate behind a single-entry valid/ready output register.
import rv_ctrl_pkg::*;

module alu_decode_stage #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      ALUop,
    output logic            ALUSrc,
    output logic            sftmd,
    output logic            Branch,
    output logic            nBranch,
    output logic            Branch_lt,
    output logic            Branch_ge,
    output logic            Branch_ltu,
    output logic            Branch_geu,
    output logic [XLEN-1:0] imm32,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    alu_ctrl_t   d_ctrl;
    imm_fmt_t    d_fmt;
    logic [31:0] d_imm;
    logic        d_mem_read, d_mem_write, d_reg_write, d_illegal;
    alu_ctrl_t   ctrl_q;
    logic        accept;

    assign opcode = in_instr[6:0];
    assign f3     = in_instr[14:12];
    assign f7     = in_instr[31:25];

    rv_imm_gen u_imm_gen (
        .fmt   (d_fmt),
        .instr (in_instr),
        .imm32 (d_imm)
    );

    always_comb begin
        d_ctrl      = '0;
        d_fmt       = IMM_NONE;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                d_reg_write = 1'b1;
                case ({f7, f3})
                    {F7_ZERO, 3'b000}: d_ctrl.alu_op = ALU_R_ADD;
                    {F7_ALT,  3'b000}: d_ctrl.alu_op = ALU_R_SUB;
                    {F7_ZERO, 3'b100}: d_ctrl.alu_op = ALU_R_XOR;
                    {F7_ZERO, 3'b110}: d_ctrl.alu_op = ALU_R_OR;
                    {F7_ZERO, 3'b111}: d_ctrl.alu_op = ALU_R_AND;
                    {F7_ZERO, 3'b001}: begin d_ctrl.alu_op = ALU_R_SLL; d_ctrl.sftmd = 1'b1; end
                    {F7_ZERO, 3'b101}: begin d_ctrl.alu_op = ALU_R_SRL; d_ctrl.sftmd = 1'b1; end
                    {F7_ALT,  3'b101}: begin d_ctrl.alu_op = ALU_R_SRA; d_ctrl.sftmd = 1'b1; end
                    default:           d_illegal = 1'b1;
                endcase
            end
            OP_I: begin
                d_ctrl.alu_src = 1'b1;
                d_reg_write    = 1'b1;
                d_fmt          = IMM_I;
                case (f3)
                    3'b000: d_ctrl.alu_op = ALU_I_ADDI;
                    3'b100: d_ctrl.alu_op = ALU_I_XORI;
                    3'b110: d_ctrl.alu_op = ALU_I_ORI;
                    3'b111: d_ctrl.alu_op = ALU_I_ANDI;
                    3'b001: begin
                        d_ctrl.alu_op = ALU_I_SLLI;
                        d_ctrl.sftmd  = 1'b1;
                        d_fmt         = IMM_SHAMT;
                        d_illegal     = (f7 != F7_ZERO);
                    end
                    3'b101: begin
                        d_ctrl.alu_op = (f7 == F7_ALT) ? ALU_I_SRAI : ALU_I_SRLI;
                        d_ctrl.sftmd  = 1'b1;
                        d_fmt         = IMM_SHAMT;
                        d_illegal     = (f7 != F7_ZERO) && (f7 != F7_ALT);
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                d_ctrl.alu_op  = ALU_ADD;
                d_ctrl.alu_src = 1'b1;
                d_mem_read     = 1'b1;
                d_reg_write    = 1'b1;
                d_fmt          = IMM_I;
                d_illegal      = (f3 != F3_W);
            end
            OP_STORE: begin
                d_ctrl.alu_op  = ALU_ADD;
                d_ctrl.alu_src = 1'b1;
                d_mem_write    = 1'b1;
                d_fmt          = IMM_S;
                d_illegal      = (f3 != F3_W);
            end
            OP_BRANCH: begin
                d_ctrl.alu_op = ALU_ADD;
                d_fmt         = IMM_B;
                case (f3)
                    F3_BEQ:  d_ctrl.branch     = 1'b1;
                    F3_BNE:  d_ctrl.n_branch   = 1'b1;
                    F3_BLT:  d_ctrl.branch_lt  = 1'b1;
                    F3_BGE:  d_ctrl.branch_ge  = 1'b1;
                    F3_BLTU: d_ctrl.branch_ltu = 1'b1;
                    F3_BGEU: d_ctrl.branch_geu = 1'b1;
                    default: d_illegal         = 1'b1;
                endcase
            end
            default: d_illegal = 1'b1;
        endcase
        // An illegal word travels as a pure bubble of control: nothing enabled.
        if (d_illegal) begin
            d_ctrl      = '0;
            d_fmt       = IMM_NONE;
            d_mem_read  = 1'b0;
            d_mem_write = 1'b0;
            d_reg_write = 1'b0;
        end
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= RESET_PC_TAG;
            ctrl_q    <= '0;
            imm32     <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            RegWrite  <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            ctrl_q    <= d_ctrl;
            imm32     <= d_imm;
            rs1       <= in_instr[19:15];
            rs2       <= in_instr[24:20];
            rd        <= in_instr[11:7];
            MemRead   <= d_mem_read;
            MemWrite  <= d_mem_write;
            RegWrite  <= d_reg_write;
            illegal   <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign ALUop      = ctrl_q.alu_op;
    assign ALUSrc     = ctrl_q.alu_src;
    assign sftmd      = ctrl_q.sftmd;
    assign Branch     = ctrl_q.branch;
    assign nBranch    = ctrl_q.n_branch;
    assign Branch_lt  = ctrl_q.branch_lt;
    assign Branch_ge  = ctrl_q.branch_ge;
    assign Branch_ltu = ctrl_q.branch_ltu;
    assign Branch_geu = ctrl_q.branch_geu;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: a reference decoder queues the
// expected bundle on each accept and the head is compared while out_valid is up.
module tb_alu_decode_stage;

    localparam logic [31:0] PC_TAG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm32;
    logic [3:0]  ALUop;
    logic        ALUSrc, sftmd, Branch, nBranch, Branch_lt, Branch_ge, Branch_ltu, Branch_geu;
    logic [4:0]  rs1, rs2, rd;
    logic        MemRead, MemWrite, RegWrite, illegal;

    always #5 clk = ~clk;

    alu_decode_stage #(.XLEN(32), .RESET_PC_TAG(PC_TAG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .ALUop(ALUop), .ALUSrc(ALUSrc), .sftmd(sftmd),
        .Branch(Branch), .nBranch(nBranch), .Branch_lt(Branch_lt),
        .Branch_ge(Branch_ge), .Branch_ltu(Branch_ltu), .Branch_geu(Branch_geu),
        .imm32(imm32), .rs1(rs1), .rs2(rs2), .rd(rd),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .illegal(illegal)
    );

    // ctrl = {illegal, ALUop, ALUSrc, sftmd, beq,bne,blt,bge,bltu,bgeu, MemRead, MemWrite, RegWrite}
    typedef struct packed {
        logic [15:0] ctrl;
        logic [31:0] imm;
        logic [14:0] regs;
        logic [31:0] pc;
    } exp_t;

    logic [15:0] dut_ctrl;
    assign dut_ctrl = {illegal, ALUop, ALUSrc, sftmd, Branch, nBranch, Branch_lt,
                       Branch_ge, Branch_ltu, Branch_geu, MemRead, MemWrite, RegWrite};

    exp_t sb_q[$];
    bit   model_valid;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rdst);
        return {f7, r2, r1, f3, rdst, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rdst,
                                          input logic [6:0] op);
        return {imm, r1, f3, rdst, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        logic [3:0]  op;
        logic        src, sft, ill, mr, mw, rw;
        logic [5:0]  br;
        logic [31:0] imm;
        op = 4'd0; src = 0; sft = 0; ill = 0; mr = 0; mw = 0; rw = 0; br = 6'd0; imm = 32'd0;
        case (i[6:0])
            7'h33: begin
                rw = 1;
                if (i[31:25] == 7'h00) begin
                    case (i[14:12])
                        3'd0: op = 4'd0;
                        3'd4: op = 4'd2;
                        3'd6: op = 4'd3;
                        3'd7: op = 4'd4;
                        3'd1: begin op = 4'd5; sft = 1; end
                        3'd5: begin op = 4'd6; sft = 1; end
                        default: ill = 1;
                    endcase
                end else if (i[31:25] == 7'h20 && i[14:12] == 3'd0) op = 4'd1;
                else if (i[31:25] == 7'h20 && i[14:12] == 3'd5) begin op = 4'd7; sft = 1; end
                else ill = 1;
            end
            7'h13: begin
                src = 1; rw = 1;
                imm = {{20{i[31]}}, i[31:20]};
                case (i[14:12])
                    3'd0: op = 4'd0;
                    3'd4: op = 4'd1;
                    3'd6: op = 4'd2;
                    3'd7: op = 4'd3;
                    3'd1: begin
                        op = 4'd4; sft = 1; imm = {27'd0, i[24:20]};
                        ill = (i[31:25] != 7'h00);
                    end
                    3'd5: begin
                        sft = 1; imm = {27'd0, i[24:20]};
                        if (i[31:25] == 7'h00) op = 4'd6;
                        else if (i[31:25] == 7'h20) op = 4'd5;
                        else ill = 1;
                    end
                    default: ill = 1;
                endcase
            end
            7'h03: begin
                src = 1; mr = 1; rw = 1; imm = {{20{i[31]}}, i[31:20]};
                ill = (i[14:12] != 3'd2);
            end
            7'h23: begin
                src = 1; mw = 1; imm = {{20{i[31]}}, i[31:25], i[11:7]};
                ill = (i[14:12] != 3'd2);
            end
            7'h63: begin
                imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                case (i[14:12])
                    3'd0: br = 6'b100000;
                    3'd1: br = 6'b010000;
                    3'd4: br = 6'b001000;
                    3'd5: br = 6'b000100;
                    3'd6: br = 6'b000010;
                    3'd7: br = 6'b000001;
                    default: ill = 1;
                endcase
            end
            default: ill = 1;
        endcase
        if (ill) begin
            op = 4'd0; src = 0; sft = 0; mr = 0; mw = 0; rw = 0; br = 6'd0; imm = 32'd0;
        end
        e.ctrl = {ill, op, src, sft, br, mr, mw, rw};
        e.imm  = imm;
        e.regs = {i[19:15], i[24:20], i[11:7]};
        e.pc   = pc;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        check("out_valid", out_valid, model_valid);
        if (model_valid) begin
            e = sb_q[0];
            check("ctrl", dut_ctrl, e.ctrl);
            check("imm32", imm32, e.imm);
            check("regs", {rs1, rs2, rd}, e.regs);
            check("out_pc", out_pc, e.pc);
        end
    endtask

    task automatic check_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_ctrl", dut_ctrl, 16'd0);
        check("rst_imm", imm32, 32'd0);
        check("rst_regs", {rs1, rs2, rd}, 15'd0);
        check("rst_pc", out_pc, PC_TAG);
    endtask

    task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input bit ordy, input bit fl);
        bit exp_rdy, acc, xfer;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !model_valid || ordy;
        check("in_ready", in_ready, exp_rdy);
        acc  = v && exp_rdy && !fl;
        xfer = model_valid && ordy;
        if (fl) sb_q.delete();
        else begin
            if (xfer) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(ref_decode(instr, pc));
        end
        model_valid = (sb_q.size() != 0);
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [31:0] vec[$];
        logic [31:0] bad[$];
        logic [31:0] pc;

        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0;
        model_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset();
        rst = 0;

        vec.push_back(32'h402081B3);                       // sub x3,x1,x2
        vec.push_back(32'h40735293);                       // srai x5,x6,7
        vec.push_back(32'hFE208CE3);                       // beq -8
        vec.push_back(32'hFE20FCE3);                       // bgeu -8
        vec.push_back(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
        vec.push_back(enc_r(7'h00, 5'd5, 5'd4, 3'd4, 5'd6));
        vec.push_back(enc_r(7'h00, 5'd7, 5'd8, 3'd6, 5'd9));
        vec.push_back(enc_r(7'h00, 5'd10, 5'd11, 3'd7, 5'd12));
        vec.push_back(enc_r(7'h00, 5'd13, 5'd14, 3'd1, 5'd15));
        vec.push_back(enc_r(7'h00, 5'd16, 5'd17, 3'd5, 5'd18));
        vec.push_back(enc_r(7'h20, 5'd19, 5'd20, 3'd5, 5'd21));
        vec.push_back(enc_i(12'hFFB, 5'd1, 3'd0, 5'd2, 7'h13));
        vec.push_back(enc_i(12'h800, 5'd3, 3'd4, 5'd4, 7'h13));
        vec.push_back(enc_i(12'h7FF, 5'd5, 3'd6, 5'd6, 7'h13));
        vec.push_back(enc_i(12'hA5A, 5'd7, 3'd7, 5'd8, 7'h13));
        vec.push_back(enc_i({7'h00, 5'd31}, 5'd9, 3'd1, 5'd10, 7'h13));
        vec.push_back(enc_i({7'h00, 5'd3}, 5'd11, 3'd5, 5'd12, 7'h13));
        vec.push_back(enc_i(12'hF00, 5'd2, 3'd2, 5'd9, 7'h03));
        vec.push_back(enc_s(12'h804, 5'd8, 5'd2, 3'd2));
        vec.push_back(enc_b(13'h0010, 5'd4, 5'd3, 3'd1));
        vec.push_back(enc_b(13'h1FFE, 5'd6, 5'd5, 3'd4));
        vec.push_back(enc_b(13'h0FFE, 5'd8, 5'd7, 3'd5));
        vec.push_back(enc_b(13'h1000, 5'd10, 5'd9, 3'd6));

        pc = 32'h0000_1000;
        foreach (vec[k]) begin
            step(1, vec[k], pc, 1, 0);
            pc += 4;
        end
        step(0, 32'h0, 32'h0, 1, 0);

        // backpressure: hold one entry, keep offering the next for three cycles
        step(1, vec[0], pc, 0, 0);
        for (int k = 0; k < 3; k++) step(1, vec[1], pc + 4, 0, 0);
        step(1, vec[1], pc + 4, 1, 0);
        step(1, vec[2], pc + 8, 1, 0);
        step(1, vec[3], pc + 12, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        pc += 16;

        // flush while holding, with a same-cycle accept that must be dropped
        step(1, vec[4], pc, 0, 0);
        step(1, vec[5], pc + 4, 1, 1);
        step(0, 32'h0, 32'h0, 1, 0);
        step(1, vec[6], pc + 8, 0, 0);
        step(1, vec[7], pc + 12, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0);
        pc += 16;

        bad.push_back(32'h00000000);
        bad.push_back(32'h0020A1B3);                       // slt
        bad.push_back(enc_i(12'd5, 5'd1, 3'd2, 5'd3, 7'h13));
        bad.push_back(enc_i(12'd0, 5'd1, 3'd0, 5'd3, 7'h03));
        bad.push_back(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3));
        bad.push_back(enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd3));
        bad.push_back(enc_i({7'h20, 5'd3}, 5'd1, 3'd1, 5'd2, 7'h13));
        bad.push_back(enc_i({7'h10, 5'd3}, 5'd1, 3'd5, 5'd2, 7'h13));
        bad.push_back(enc_s(12'h010, 5'd2, 5'd1, 3'd0));
        bad.push_back(enc_b(13'h0008, 5'd2, 5'd1, 3'd2));
        bad.push_back(32'h0000006F);                       // jal
        foreach (bad[k]) begin
            step(1, bad[k], pc, 1, 0);
            pc += 4;
        end
        step(0, 32'h0, 32'h0, 1, 0);

        // reset while an entry is held and another is offered
        step(1, vec[8], pc, 0, 0);
        rst = 1;
        in_valid = 1;
        in_instr = vec[9];
        @(posedge clk);
        @(negedge clk);
        check_reset();
        sb_q.delete();
        model_valid = 0;
        rst = 0;
        step(1, vec[10], pc + 4, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
